// File: rtl/vga_pkg.sv
// Shared VGA timing types, default 640x480@60 timing and helpers used to size
// and decode the horizontal/vertical counters.
package vga_pkg;

    typedef enum logic [1:0] {VISIBLE, FRONT, SYNC, BACK} vga_phase_t;

    localparam int DEF_CLK_DIV = 2;
    localparam int DEF_H_VIS   = 640;
    localparam int DEF_H_FP    = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BP    = 48;
    localparam int DEF_V_VIS   = 480;
    localparam int DEF_V_FP    = 10;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BP    = 33;

    function automatic int vga_total(input int vis, input int fp, input int sync_w, input int bp);
        return vis + fp + sync_w + bp;
    endfunction

    // Phase of a counter value; the back porch runs up to TOTAL-1.
    function automatic vga_phase_t vga_phase(input int cnt, input int vis, input int fp,
                                             input int sync_w);
        if (cnt < vis)
            return VISIBLE;
        else if (cnt < vis + fp)
            return FRONT;
        else if (cnt < vis + fp + sync_w)
            return SYNC;
        return BACK;
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Divides the system clock into a one-clk pixel enable every CLK_DIV clocks.
// clr restarts the count so the next tick lands CLK_DIV clocks later.
module vga_pix_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster scheduler: pixel/line counters, horizontal and vertical phase FSMs
// and registered sync/video/frame decodes, all advanced by the pixel enable.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_VIS    = DEF_H_VIS,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_VIS    = DEF_V_VIS,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    output logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [$clog2(vga_total(H_VIS, H_FP, H_SYNC, H_BP))-1:0] pixel_x,
    output logic [$clog2(vga_total(V_VIS, V_FP, V_SYNC, V_BP))-1:0] pixel_y,
    output logic       frame_start,
    output vga_phase_t h_state,
    output vga_phase_t v_state
);

    localparam int H_TOTAL = vga_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_VIS, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    // Cleared by reset/restart: the first tick afterwards enters (0,0)
    // instead of advancing, so pixel (0,0) is presented with frame_start.
    logic          started;
    logic [HW-1:0] x_next;
    logic [VW-1:0] y_next;
    vga_phase_t    h_next;
    vga_phase_t    v_next;

    vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .tick (pix_tick)
    );

    always_comb begin
        x_next = pixel_x;
        y_next = pixel_y;
        if (started) begin
            if (pixel_x >= H_LAST) begin
                x_next = '0;
                y_next = (pixel_y >= V_LAST) ? '0 : pixel_y + 1'b1;
            end else begin
                x_next = pixel_x + 1'b1;
            end
        end
        h_next = vga_phase(int'(x_next), H_VIS, H_FP, H_SYNC);
        v_next = vga_phase(int'(y_next), V_VIS, V_FP, V_SYNC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started     <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            h_state     <= VISIBLE;
            v_state     <= VISIBLE;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else if (restart) begin
            started     <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            h_state     <= VISIBLE;
            v_state     <= VISIBLE;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_tick) begin
            started     <= 1'b1;
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            h_state     <= h_next;
            v_state     <= v_next;
            hsync       <= (h_next == SYNC) ? SYNC_ON : SYNC_OFF;
            vsync       <= (v_next == SYNC) ? SYNC_ON : SYNC_OFF;
            video_on    <= (h_next == VISIBLE) && (v_next == VISIBLE);
            frame_start <= (x_next == '0) && (y_next == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default-width instance (short frame) and a tiny
// instance, both tracked every clock against an arithmetic raster model.
module tb_vga_timing_ctrl;
    import vga_pkg::*;

    localparam int A_DIV = 2;
    localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VV = 4, A_VF = 1, A_VS = 2, A_VB = 1;
    localparam bit A_POL = 1'b0;
    localparam int A_HT = A_HV + A_HF + A_HS + A_HB;
    localparam int A_VT = A_VV + A_VF + A_VS + A_VB;

    localparam int B_DIV = 3;
    localparam int B_HV = 4, B_HF = 1, B_HS = 1, B_HB = 1;
    localparam int B_VV = 3, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam bit B_POL = 1'b1;
    localparam int B_HT = B_HV + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VV + B_VF + B_VS + B_VB;

    typedef struct {
        int x; int y; int hs; int vs; int vid; int fs; int hp; int vp;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic rst_a = 1'b1, restart_a = 1'b0;
    logic rst_b = 1'b1, restart_b = 1'b0;
    bit   done = 1'b0;

    logic pix_tick_a, hsync_a, vsync_a, video_on_a, frame_start_a;
    logic [$clog2(A_HT)-1:0] pixel_x_a;
    logic [$clog2(A_VT)-1:0] pixel_y_a;
    vga_phase_t h_state_a, v_state_a;

    logic pix_tick_b, hsync_b, vsync_b, video_on_b, frame_start_b;
    logic [$clog2(B_HT)-1:0] pixel_x_b;
    logic [$clog2(B_VT)-1:0] pixel_y_b;
    vga_phase_t h_state_b, v_state_b;

    vga_timing_ctrl #(
        .CLK_DIV(A_DIV), .H_VIS(A_HV), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_VIS(A_VV), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB), .SYNC_POL(A_POL)
    ) dut_a (
        .clk(clk), .rst(rst_a), .restart(restart_a), .pix_tick(pix_tick_a),
        .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
        .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .frame_start(frame_start_a),
        .h_state(h_state_a), .v_state(v_state_a)
    );

    vga_timing_ctrl #(
        .CLK_DIV(B_DIV), .H_VIS(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_VIS(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .SYNC_POL(B_POL)
    ) dut_b (
        .clk(clk), .rst(rst_b), .restart(restart_b), .pix_tick(pix_tick_b),
        .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
        .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .frame_start(frame_start_b),
        .h_state(h_state_b), .v_state(v_state_b)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int phase_of(input int c, input int vis, input int fp, input int sw);
        if (c < vis) return int'(VISIBLE);
        if (c < vis + fp) return int'(FRONT);
        if (c < vis + fp + sw) return int'(SYNC);
        return int'(BACK);
    endfunction

    // n = pixels presented since the last reset/restart (-1: none yet).
    function automatic exp_t model_out(input int n, input int hv, input int hf, input int hs,
                                       input int hb, input int vv, input int vf, input int vs,
                                       input int vb, input bit pol);
        exp_t e;
        int ht, vt;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        if (n < 0) begin
            e.x = 0; e.y = 0; e.hs = !pol; e.vs = !pol; e.vid = 0; e.fs = 0;
            e.hp = int'(VISIBLE); e.vp = int'(VISIBLE);
        end else begin
            e.x   = n % ht;
            e.y   = (n / ht) % vt;
            e.hs  = (e.x >= hv + hf && e.x < hv + hf + hs) ? pol : !pol;
            e.vs  = (e.y >= vv + vf && e.y < vv + vf + vs) ? pol : !pol;
            e.vid = (e.x < hv && e.y < vv);
            e.fs  = (e.x == 0 && e.y == 0);
            e.hp  = phase_of(e.x, hv, hf, hs);
            e.vp  = phase_of(e.y, vv, vf, vs);
        end
        return e;
    endfunction

    int   ca = 0, na = -1;
    bit   ta = 1'b0;
    exp_t ea;
    always @(posedge clk) begin
        if (rst_a || restart_a) begin
            ca = 0; na = -1; ta = 1'b0;
        end else begin
            if (ta) na++;
            ca++;
            ta = (ca % A_DIV == 0);
        end
        ea = model_out(na, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_POL);
        #1;
        check("a_tick", pix_tick_a, ta);
        check("a_x", pixel_x_a, ea.x);
        check("a_y", pixel_y_a, ea.y);
        check("a_hsync", hsync_a, ea.hs);
        check("a_vsync", vsync_a, ea.vs);
        check("a_video", video_on_a, ea.vid);
        check("a_frame", frame_start_a, ea.fs);
        check("a_hstate", h_state_a, ea.hp);
        check("a_vstate", v_state_a, ea.vp);
    end

    int   cb = 0, nb = -1;
    bit   tb = 1'b0;
    exp_t eb;
    always @(posedge clk) begin
        if (rst_b || restart_b) begin
            cb = 0; nb = -1; tb = 1'b0;
        end else begin
            if (tb) nb++;
            cb++;
            tb = (cb % B_DIV == 0);
        end
        eb = model_out(nb, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_POL);
        #1;
        check("b_tick", pix_tick_b, tb);
        check("b_x", pixel_x_b, eb.x);
        check("b_y", pixel_y_b, eb.y);
        check("b_hsync", hsync_b, eb.hs);
        check("b_vsync", vsync_b, eb.vs);
        check("b_video", video_on_b, eb.vid);
        check("b_frame", frame_start_b, eb.fs);
        check("b_hstate", h_state_b, eb.hp);
        check("b_vstate", v_state_b, eb.vp);
    end

    // ---------------- driver tasks ----------------
    // Returns just after the edge at which the counters consumed a pixel tick.
    task automatic wait_tick;
        int b;
        b = 0;
        @(negedge clk);
        while (!pix_tick_a && b < 4 * A_DIV) begin
            @(negedge clk);
            b++;
        end
        check("tick_wait", pix_tick_a, 1);
        @(posedge clk);
        #1;
    endtask

    int t0;

    // Called at a negedge with rst_a high; releases it and checks the start-up sequence.
    task automatic release_check(input string tag);
        rst_a = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            check({tag, "_tick"}, pix_tick_a, (e % 2 == 0));
            if (e <= 2) begin
                check({tag, "_x_hold"}, pixel_x_a, 0);
                check({tag, "_vid_hold"}, video_on_a, 0);
                check({tag, "_fs_hold"}, frame_start_a, 0);
                check({tag, "_hs_hold"}, hsync_a, !A_POL);
            end
            if (e == 3) begin
                t0 = cyc;
                check({tag, "_fs_first"}, frame_start_a, 1);
                check({tag, "_vid_first"}, video_on_a, 1);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    int hs_low, hs_first, vid_cnt, vs_low, vs_first, vs_last, t1;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_x", pixel_x_a, 0);
        check("rst_hsync", hsync_a, !A_POL);
        check("rst_tick", pix_tick_a, 0);
        release_check("s1");

        // One full line from (0,0).
        hs_low = 0; hs_first = -1;
        for (int i = 0; i < A_HT; i++) begin
            if (pixel_y_a == 0 && hsync_a == A_POL) begin
                if (hs_first < 0) hs_first = int'(pixel_x_a);
                hs_low++;
            end
            if (i == A_HT - 1) begin
                check("s2_pre_x", pixel_x_a, A_HT - 1);
                check("s2_pre_y", pixel_y_a, 0);
            end
            wait_tick();
        end
        check("s2_hs_len", hs_low, A_HS);
        check("s2_hs_start", hs_first, A_HV + A_HF);
        check("s2_wrap_x", pixel_x_a, 0);
        check("s2_wrap_y", pixel_y_a, 1);

        // Frame period and per-frame statistics.
        for (int i = 0; i < A_HT * A_VT && !frame_start_a; i++) wait_tick();
        t1 = cyc;
        check("s3_period0", t1 - t0, A_HT * A_VT * A_DIV);
        vid_cnt = 0; vs_low = 0; vs_first = -1; vs_last = -1;
        for (int i = 0; i < A_HT * A_VT; i++) begin
            if (video_on_a) vid_cnt++;
            if (vsync_a == A_POL) begin
                vs_low++;
                if (vs_first < 0) vs_first = int'(pixel_y_a);
                vs_last = int'(pixel_y_a);
            end
            wait_tick();
        end
        check("s3_fs_again", frame_start_a, 1);
        check("s3_period1", cyc - t1, A_HT * A_VT * A_DIV);
        check("s3_vid_cnt", vid_cnt, A_HV * A_VV);
        check("s3_vs_ticks", vs_low, A_HT * A_VS);
        check("s3_vs_first", vs_first, A_VV + A_VF);
        check("s3_vs_last", vs_last, A_VV + A_VF + A_VS - 1);

        // Restart inside both sync pulses, coincident with a pixel tick.
        for (int i = 0; i < A_HT * A_VT && !(pixel_x_a == 700 && pixel_y_a == 5); i++)
            wait_tick();
        check("s5_at_x", pixel_x_a, 700);
        check("s5_at_y", pixel_y_a, 5);
        for (int i = 0; i < 4 * A_DIV && !pix_tick_a; i++) @(negedge clk);
        check("s5_coinc_tick", pix_tick_a, 1);
        restart_a = 1'b1;
        @(posedge clk);
        #1;
        check("s5_x", pixel_x_a, 0);
        check("s5_y", pixel_y_a, 0);
        check("s5_hsync", hsync_a, !A_POL);
        check("s5_vsync", vsync_a, !A_POL);
        check("s5_vid", video_on_a, 0);
        check("s5_fs", frame_start_a, 0);
        @(negedge clk);
        restart_a = 1'b0;
        wait_tick();
        check("s5_fs_next", frame_start_a, 1);
        check("s5_vid_next", video_on_a, 1);

        // Asynchronous reset in the middle of hsync.
        for (int i = 0; i < A_HT && pixel_x_a != 700; i++) wait_tick();
        check("s6_at_x", pixel_x_a, 700);
        check("s6_hs_active", hsync_a, A_POL);
        #3;
        rst_a = 1'b1;
        #1;
        check("s6_x", pixel_x_a, 0);
        check("s6_hsync", hsync_a, !A_POL);
        check("s6_vid", video_on_a, 0);
        check("s6_tick", pix_tick_a, 0);
        check("s6_fs", frame_start_a, 0);
        @(negedge clk);
        @(negedge clk);
        release_check("s6");

        // Random restarts on the wide instance.
        repeat (3000) begin
            @(negedge clk);
            restart_a = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        restart_a = 1'b0;
        done = 1'b1;
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Tiny instance: three undisturbed frames, then random restarts and resets.
    initial begin
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        repeat (3 * B_HT * B_VT * B_DIV + 20) @(negedge clk);
        while (!done) begin
            @(negedge clk);
            restart_b = ($urandom_range(0, 149) == 0);
            rst_b     = ($urandom_range(0, 799) == 0);
        end
        restart_b = 1'b0;
        rst_b     = 1'b0;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
